// File: rtl/writeback_arbiter_if.sv
// Write-back bus bundle: ALU result, load handshake, register-file write port
// and the hazard/status outputs. Producers use 'master', the arbiter 'slave'.
interface writeback_arbiter_if #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
);
    logic                            AluValid;
    logic [ADDR_W-1:0]               AluRD;
    logic [DATA_W-1:0]               AluData;
    logic                            MemValid;
    logic [ADDR_W-1:0]               MemRD;
    logic [DATA_W-1:0]               MemData;
    logic                            MemReady;
    logic [ADDR_W-1:0]               RD;
    logic [DATA_W-1:0]               WriteData;
    logic                            RegWrite;
    logic [(2**ADDR_W)-1:0]          Pending;
    logic [$clog2(FIFO_DEPTH):0]     FifoCount;

    modport master (
        output AluValid, AluRD, AluData, MemValid, MemRD, MemData,
        input  MemReady, RD, WriteData, RegWrite, Pending, FifoCount
    );

    modport slave (
        input  AluValid, AluRD, AluData, MemValid, MemRD, MemData,
        output MemReady, RD, WriteData, RegWrite, Pending, FifoCount
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: the ALU always wins the register-file write port; load
// results are queued in an in-order FIFO and drained when the ALU is idle.
// An ALU write kills older queued loads to the same register so a stale load
// can never overwrite a newer ALU result.
module writeback_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    writeback_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic [ADDR_W-1:0] entryRd   [FIFO_DEPTH];
    logic [DATA_W-1:0] entryData [FIFO_DEPTH];
    logic              entryLive [FIFO_DEPTH];

    logic [PTR_W-1:0]  rdPtrReg;
    logic [PTR_W-1:0]  wrPtrReg;
    logic [CNT_W-1:0]  countReg;
    logic [NREG-1:0]   pendingVec;

    logic memReady;
    logic push;
    logic pop;
    logic pushLive;

    // Ready depends only on stored count, so a full FIFO never pushes even
    // when the head is popped in the same cycle.
    assign memReady = ResetN && (countReg < CNT_W'(FIFO_DEPTH));
    assign push     = bus.MemValid && memReady;
    assign pop      = !bus.AluValid && (countReg != '0);
    // A load arriving together with an ALU write to the same register is older.
    assign pushLive = !(bus.AluValid && (bus.MemRD == bus.AluRD));

    assign bus.MemReady  = memReady;
    assign bus.FifoCount = countReg;
    assign bus.Pending   = pendingVec;

    // Entry payload storage; occupancy is tracked by pointers and live bits.
    always_ff @(posedge Clock) begin
        if (push) begin
            entryRd[wrPtrReg]   <= bus.MemRD;
            entryData[wrPtrReg] <= bus.MemData;
        end
    end

    // Per-entry live bit: set on push, cleared on pop or by a matching ALU write.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gLive
            always_ff @(posedge Clock or negedge ResetN) begin
                if (!ResetN)
                    entryLive[gi] <= 1'b0;
                else if (push && (wrPtrReg == PTR_W'(gi)))
                    entryLive[gi] <= pushLive;
                else if (pop && (rdPtrReg == PTR_W'(gi)))
                    entryLive[gi] <= 1'b0;
                else if (bus.AluValid && (entryRd[gi] == bus.AluRD))
                    entryLive[gi] <= 1'b0;
            end
        end
    endgenerate

    // Circular-buffer pointers and occupancy count.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rdPtrReg <= '0;
            wrPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (push) wrPtrReg <= wrPtrReg + 1'b1;
            if (pop)  rdPtrReg <= rdPtrReg + 1'b1;
            case ({push, pop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    // Registered write port: ALU first, then a live FIFO head; a killed head
    // is consumed silently.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            bus.RD        <= '0;
            bus.WriteData <= '0;
            bus.RegWrite  <= 1'b0;
        end else if (bus.AluValid) begin
            bus.RD        <= bus.AluRD;
            bus.WriteData <= bus.AluData;
            bus.RegWrite  <= 1'b1;
        end else if (pop) begin
            bus.RegWrite <= entryLive[rdPtrReg];
            if (entryLive[rdPtrReg]) begin
                bus.RD        <= entryRd[rdPtrReg];
                bus.WriteData <= entryData[rdPtrReg];
            end
        end else begin
            bus.RegWrite <= 1'b0;
        end
    end

    // Hazard vector from live stored entries only.
    always_comb begin
        pendingVec = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entryLive[i]) pendingVec[entryRd[i]] = 1'b1;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench: stimulus pushes the expected write sequence into a queue,
// a negedge monitor pops and compares every RegWrite pulse.
module tb_writeback_arbiter;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 3;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic Clock;
    logic ResetN;
    int   checks;
    int   errors;
    wr_t  expQ[$];

    writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every issued write must match the next expected one.
    always @(negedge Clock) begin
        if (ResetN && bus.RegWrite) begin
            wr_t e;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got RD=%0d data=0x%04h expected no write",
                         bus.RD, bus.WriteData);
            end else begin
                e = expQ.pop_front();
                if (bus.RD !== e.rd || bus.WriteData !== e.data) begin
                    errors++;
                    $display("FAIL write: got RD=%0d data=0x%04h expected RD=%0d data=0x%04h",
                             bus.RD, bus.WriteData, e.rd, e.data);
                end else begin
                    $display("write RD=%0d data=0x%04h ok", bus.RD, bus.WriteData);
                end
            end
        end
    end

    task automatic drive(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                         input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
        bus.AluValid = av;  bus.AluRD = ard; bus.AluData = ad;
        bus.MemValid = mv;  bus.MemRD = mrd; bus.MemData = md;
    endtask

    // Apply inputs for one cycle; returns #1 after the rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        wr_t e;
        e.rd = rd; e.data = data;
        expQ.push_back(e);
    endtask

    initial begin
        int loadIdx;
        int maxCount;
        logic accepted;
        checks = 0;
        errors = 0;

        // ---- Reset with both sources active ----
        ResetN = 1'b0;
        drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
        step(); step();
        check("reset_regwrite",  32'(bus.RegWrite),  32'd0);
        check("reset_memready",  32'(bus.MemReady),  32'd0);
        check("reset_pending",   32'(bus.Pending),   32'd0);
        check("reset_fifocount", 32'(bus.FifoCount), 32'd0);
        check("reset_rd",        32'(bus.RD),        32'd0);
        check("reset_wdata",     32'(bus.WriteData), 32'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        ResetN = 1'b1;
        step();
        check("release_memready", 32'(bus.MemReady), 32'd1);

        // ---- ALU only ----
        push_exp(3'd5, 16'h1234);
        drive(1'b1, 3'd5, 16'h1234, 1'b0, '0, '0);
        step();
        check("alu_regwrite", 32'(bus.RegWrite), 32'd1);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        check("alu_regwrite_drop", 32'(bus.RegWrite), 32'd0);

        // ---- Single load ----
        push_exp(3'd2, 16'hBEEF);
        drive(1'b0, '0, '0, 1'b1, 3'd2, 16'hBEEF);
        check("load_ready", 32'(bus.MemReady), 32'd1);
        step();
        check("load_pending",   32'(bus.Pending),   32'h04);
        check("load_count",     32'(bus.FifoCount), 32'd1);
        check("load_no_bypass", 32'(bus.RegWrite),  32'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        check("load_issue",         32'(bus.RegWrite),  32'd1);
        check("load_pending_clear", 32'(bus.Pending),   32'h00);
        check("load_count_empty",   32'(bus.FifoCount), 32'd0);
        step();

        // ---- Full / back-pressure: 6 ALU cycles, 5 loads R0..R4 ----
        for (int k = 0; k < 6; k++) push_exp(3'd7, 16'h7000 + 16'(k));
        for (int k = 0; k < 5; k++) push_exp(3'(k), 16'hD000 + 16'(k));
        loadIdx  = 0;
        maxCount = 0;
        for (int c = 0; c < 14; c++) begin
            drive(c < 6, 3'd7, 16'h7000 + 16'(c),
                  loadIdx < 5, 3'(loadIdx), 16'hD000 + 16'(loadIdx));
            accepted = bus.MemValid && bus.MemReady;
            step();
            if (accepted) loadIdx++;
            if (int'(bus.FifoCount) > maxCount) maxCount = int'(bus.FifoCount);
            if (c == 5) begin
                check("full_count",    32'(bus.FifoCount), 32'd4);
                check("full_memready", 32'(bus.MemReady),  32'd0);
                check("full_r4_held",  32'(loadIdx),       32'd4);
                check("full_pending",  32'(bus.Pending),   32'h0F);
            end
        end
        check("full_max_count", 32'(maxCount),      32'd4);
        check("full_all_loads", 32'(loadIdx),       32'd5);
        check("full_drained",   32'(bus.FifoCount), 32'd0);

        // ---- Kill: load R3 then ALU R3 ----
        push_exp(3'd3, 16'h2222);
        drive(1'b0, '0, '0, 1'b1, 3'd3, 16'h1111);
        step();
        check("kill_pending_set", 32'(bus.Pending), 32'h08);
        drive(1'b1, 3'd3, 16'h2222, 1'b0, '0, '0);
        step();
        check("kill_pending_clear", 32'(bus.Pending),   32'h00);
        check("kill_count_held",    32'(bus.FifoCount), 32'd1);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        check("kill_drop_regwrite", 32'(bus.RegWrite),  32'd0);
        check("kill_drop_count",    32'(bus.FifoCount), 32'd0);
        step();

        // ---- Simultaneous same register ----
        push_exp(3'd6, 16'h5555);
        drive(1'b1, 3'd6, 16'h5555, 1'b1, 3'd6, 16'hAAAA);
        step();
        check("same_count1",  32'(bus.FifoCount), 32'd1);
        check("same_pending", 32'(bus.Pending),   32'h00);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        check("same_count0",   32'(bus.FifoCount), 32'd0);
        check("same_regwrite", 32'(bus.RegWrite),  32'd0);
        check("same_pending2", 32'(bus.Pending),   32'h00);
        step(); step();

        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
